pipe_sched: RTL and testbench
=============================

PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 SHALL have parameter WID, default 8: width of datapath result word.
REQ-002 SHALL have parameter LAT, default 4: latency in ce-qualified cycles of the external delay chain (LAT >= 1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ce  input  1  global clock enable; low freezes all state.
REQ-006 SHALL have port i_valid  input  1  upstream request to enter pipeline.
REQ-007 SHALL have port i_ready  output  1  request accepted this cycle when i_valid & i_ready.
REQ-008 SHALL have port dp_ce  output  1  clock enable driven to every stage of the external delay chain.
REQ-009 SHALL have port dp_o  input  WID  output of external delay chain.
REQ-010 SHALL have port o_valid  output  1  result available.
REQ-011 SHALL have port o_ready  input  1  downstream accepts result.
REQ-012 SHALL have port o_data  output  WID  result word.
REQ-013 SHALL have port flush_req  input  1  request to drain pipeline.
REQ-014 SHALL have port flush_done  output  1  one-cycle pulse, pipeline empty after flush.
REQ-015 SHALL have port occ  output  OCCW  tokens in flight (chain + skid), OCCW = clog2(LAT+3).

Function
REQ-016 SHALL keep an LAT-bit valid shift register v, advanced only when dp_ce; v[0] <= i_valid & i_ready.
REQ-017 SHALL assert dp_ce = ce & (~v[LAT-1] | space), where space is defined per REQ-030/031.
REQ-018 SHALL drive i_ready = dp_ce & (state == RUN).
REQ-019 SHALL implement states RUN, DRAIN, DONE.
REQ-020 RUN -> DRAIN on flush_req & ce; an accept in the same cycle is still taken and counted.
REQ-021 DRAIN: i_ready = 0, bubbles enter v[0]; flush_req ignored; DRAIN -> DONE when occ == 0.
REQ-022 DONE: flush_done = 1 for exactly one cycle; DONE -> RUN next ce cycle.
REQ-023 flush_req with occ == 0 in RUN SHALL still pass through DRAIN (one cycle) then DONE.
REQ-024 occ SHALL increment on accept, decrement on o_valid & o_ready & ce, unchanged when both or neither.
REQ-025 With ce low, dp_ce, i_ready and flush_done SHALL be 0 and no token SHALL be lost or duplicated.
REQ-026 A token entering at accept SHALL reach o_valid after exactly LAT dp_ce cycles (+1 cycle with skid).
REQ-027 Tokens SHALL leave in acceptance order, none dropped under any o_ready pattern.

Reset
REQ-028 rst SHALL clear v, occ, skid buffer and force state RUN asynchronously, including mid-DRAIN.
REQ-029 Reset values: i_ready 0 until rst deasserts, dp_ce 0, o_valid 0, o_data 0, flush_done 0, occ 0.

Configuration
REQ-030 Macro PIPE_SCHED_SKID_EN defined: 2-entry skid buffer captures dp_o when v[LAT-1] & dp_ce; space = (skid_cnt != 2) from registers only; o_valid = skid_cnt != 0; o_data = skid head; occ max LAT+2.
REQ-031 Macro undefined: no skid; space = o_ready (combinational); o_valid = v[LAT-1]; o_data = dp_o; occ max LAT.

Structure
REQ-032 Package pipe_sched_pkg SHALL hold the state enum (RUN, DRAIN, DONE) and the OCCW width function.
REQ-033 Skid buffer SHALL be sub-module pipe_sched_skid (WID, 2 entries, push/pop/count), instantiated only under PIPE_SCHED_SKID_EN.

Verification
REQ-034 LAT=4, o_ready=1, i_valid held 10 cycles, data tags 1..10 -> o_valid first 4 (5 skid) cycles later, tags 1..10 in order, occ peaks at 4.
REQ-035 Fill 4 tokens, o_ready=0 for 6 cycles -> dp_ce=0 once v[3] set (skid: once skid full), i_ready=0, occ=4 (6 skid), no tag lost on release.
REQ-036 3 tokens in flight, flush_req pulse with i_valid=1 -> that accept counted, i_ready=0 after, flush_done single pulse when occ reaches 0, 4 tags emerge.
REQ-037 ce toggled 1-0-1-0 during steady streaming -> output tag sequence identical to ce=1 run, only stretched.
REQ-038 rst asserted mid-DRAIN with occ=2 -> occ=0, o_valid=0, flush_done=0 immediately; state RUN after deassert.
REQ-039 o_ready random 50% over 1000 tokens, both macro settings -> scoreboard match, occ never exceeds LAT (LAT+2 skid).

Source files
------------

// File: rtl/pipe_sched_pkg.sv
// Shared definitions for the pipe_sched scheduler.
//
// Holds the flush state encoding and the helper that sizes the occupancy
// counter. The counter must represent every token that can be in flight:
// LAT in the delay chain plus up to two in the optional skid buffer.
package pipe_sched_pkg;

    // Flush handshake states: normal streaming, draining, one-cycle done.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of the occupancy counter for a chain of the given latency.
    function automatic int occ_width(input int lat);
        return $clog2(lat + 3);
    endfunction

endpackage

// File: rtl/pipe_sched_skid.sv
// Two-entry skid buffer for pipe_sched.
//
// Catches results leaving the external delay chain so the chain can keep
// moving for a couple of cycles after downstream stops accepting. The entry
// at slot0 is always the oldest and is presented on head.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, empties the buffer
//   push   - write din this cycle (caller guarantees count < 2)
//   pop    - drop the head entry this cycle (caller guarantees count > 0)
//   din    - data to capture
//   head   - oldest stored entry
//   count  - number of valid entries, 0..2
module pipe_sched_skid #(
    parameter int WID = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [WID-1:0] din,
    output logic [WID-1:0] head,
    output logic [1:0]     count
);

    logic [WID-1:0] slot0;
    logic [WID-1:0] slot1;

    // Entries shift toward slot0 on pop; a push lands in the first free slot
    // after any pop of the same cycle has been accounted for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= din;
                    end else begin
                        slot1 <= din;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = slot0;

endmodule

// File: rtl/pipe_sched.sv
// Valid/ready scheduler wrapped around an external fixed-latency delay chain.
//
// The chain itself lives outside this block; pipe_sched tracks which chain
// stages hold real tokens (v), decides when the chain may advance (dp_ce),
// exposes a valid/ready handshake on both sides, counts tokens in flight and
// runs a flush handshake that stops intake until the pipeline is empty.
//
// Build option: define PIPE_SCHED_SKID_EN to add a two-entry skid buffer on
// the output, which breaks the combinational o_ready -> dp_ce path at the
// cost of one extra cycle of latency.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   ce         - global clock enable, low freezes all state
//   i_valid    - upstream request
//   i_ready    - request accepted when i_valid & i_ready
//   dp_ce      - enable for every stage of the external chain
//   dp_o       - output of the external chain
//   o_valid    - result available
//   o_ready    - downstream accepts result
//   o_data     - result word (zero when o_valid is low)
//   flush_req  - request to drain the pipeline
//   flush_done - one-cycle pulse once the pipeline is empty after a flush
//   occ        - tokens in flight (chain plus skid)
module pipe_sched
    import pipe_sched_pkg::*;
#(
    parameter  int WID  = 8,
    parameter  int LAT  = 4,
    localparam int OCCW = occ_width(LAT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            i_valid,
    output logic            i_ready,
    output logic            dp_ce,
    input  logic [WID-1:0]  dp_o,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [WID-1:0]  o_data,
    input  logic            flush_req,
    output logic            flush_done,
    output logic [OCCW-1:0] occ
);

    state_t         state;
    state_t         state_next;
    logic [LAT-1:0] v;
    logic [LAT-1:0] v_shift;
    logic           space;
    logic           accept;
    logic           pop;
    logic           tail;

    assign tail   = v[LAT-1];
    assign accept = i_valid & i_ready;
    assign pop    = o_valid & o_ready & ce;

`ifdef PIPE_SCHED_SKID_EN
    logic [1:0]     skid_count;
    logic [WID-1:0] skid_head;
    logic           skid_push;

    // A token leaving the chain is captured whenever the chain advances.
    assign skid_push = tail & dp_ce;

    pipe_sched_skid #(.WID(WID)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (skid_push),
        .pop   (pop),
        .din   (dp_o),
        .head  (skid_head),
        .count (skid_count)
    );

    // Room is judged from the skid count register alone, so o_ready never
    // reaches dp_ce combinationally.
    assign space   = (skid_count != 2'd2);
    assign o_valid = (skid_count != 2'd0);
    assign o_data  = o_valid ? skid_head : '0;
`else
    assign space   = o_ready;
    assign o_valid = tail;
    assign o_data  = o_valid ? dp_o : '0;
`endif

    // The chain may advance unless its last stage holds a token with nowhere
    // to go. Held low during reset so the external chain stays frozen.
    assign dp_ce = ce & ~rst & (~tail | space);

    // Next contents of the valid tracker: shift by one stage, new token (or
    // bubble) enters stage 0. Written this way so LAT = 1 needs no special case.
    always_comb begin
        v_shift    = v << 1;
        v_shift[0] = accept;
    end

    // Valid tracker moves in lockstep with the external chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else if (dp_ce) begin
            v <= v_shift;
        end
    end

    // Occupancy follows the two handshakes; simultaneous accept and pop
    // cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + OCCW'(1);
                2'b01:   occ <= occ - OCCW'(1);
                default: ;
            endcase
        end
    end

    // Flush state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Flush sequencing. Every transition waits for ce so a low ce freezes the
    // handshake. DRAIN always lasts at least one cycle, even when the
    // pipeline is already empty, because occ is checked from DRAIN itself.
    always_comb begin
        state_next = state;
        if (ce) begin
            case (state)
                RUN:     if (flush_req) state_next = DRAIN;
                DRAIN:   if (occ == '0) state_next = DONE;
                DONE:    state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    // Intake is open only while streaming; the done pulse is gated by ce so
    // it cannot appear during a frozen cycle.
    always_comb begin
        i_ready    = dp_ce & (state == RUN);
        flush_done = ce & (state == DONE);
    end

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched with LAT = 4, WID = 8.
//
// The bench models the external delay chain itself and keeps a queue of
// accepted tags to check result order. Expected latencies and occupancy
// limits are hand values for LAT = 4 in both builds (PIPE_SCHED_SKID_EN
// defined or not).
`timescale 1ns/1ps
module tb_pipe_sched;
    import pipe_sched_pkg::*;

    localparam int WID  = 8;
    localparam int LAT  = 4;
    localparam int OCCW = occ_width(LAT);

`ifdef PIPE_SCHED_SKID_EN
    localparam int OUT_LAT   = 5;
    localparam int OCC_PEAK1 = 5;
    localparam int OCC_FULL  = 6;
    localparam int FLUSH_CYC = 10;
    localparam int OCC_MAX   = 6;
`else
    localparam int OUT_LAT   = 4;
    localparam int OCC_PEAK1 = 4;
    localparam int OCC_FULL  = 4;
    localparam int FLUSH_CYC = 9;
    localparam int OCC_MAX   = 4;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      ce = 1'b0;
    logic                      i_valid = 1'b0;
    logic                      i_ready;
    logic                      dp_ce;
    logic [WID-1:0]            dp_o;
    logic                      o_valid;
    logic                      o_ready = 1'b0;
    logic [WID-1:0]            o_data;
    logic                      flush_req = 1'b0;
    logic                      flush_done;
    logic [OCCW-1:0]           occ;
    logic [WID-1:0]            inData = '0;
    logic [LAT-1:0][WID-1:0]   chain = '0;

    logic [WID-1:0] expQueue[$];
    int             numChecks = 0;
    int             numFails = 0;
    int             popCount = 0;
    int             peakOcc = 0;

    pipe_sched #(.WID(WID), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .dp_ce      (dp_ce),
        .dp_o       (dp_o),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .occ        (occ)
    );

    always #5 clk = ~clk;

    // Stand-in for the external delay chain: every stage shares dp_ce.
    always @(posedge clk) begin
        if (dp_ce) begin
            chain <= {chain[LAT-2:0], inData};
        end
    end

    assign dp_o = chain[LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [WID-1:0] data,
                                 input logic ordy, input logic flush,
                                 input logic ceVal);
        i_valid   = valid;
        inData    = data;
        o_ready   = ordy;
        flush_req = flush;
        ce        = ceVal;
        #1;
    endtask

    // Predicts the handshakes of the coming edge from the settled inputs and
    // outputs, updates the scoreboard, then steps to just after the edge.
    task automatic nextCycle();
        #1;
        if (rst) begin
            expQueue.delete();
        end else begin
            if (o_valid && o_ready && ce) begin
                popCount++;
                if (expQueue.size() == 0) begin
                    checkOutput("sb_underflow", 32'(expQueue.size()), 32'd1);
                end else begin
                    checkOutput("sb_order", 32'(o_data), 32'(expQueue.pop_front()));
                end
            end
            if (i_valid && i_ready) begin
                expQueue.push_back(inData);
            end
            if (int'(occ) > peakOcc) begin
                peakOcc = int'(occ);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WID-1:0] tag;
        logic           accepted;
        int             acc;
        int             doneCount;
        int             doneAt;
        int             popBase;
        int             cycles;
        logic [OCCW-1:0] occHold;

        // Reset state
        $display("[TB] reset");
        applyStimulus(1'b1, 8'd0, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rst_i_ready", 32'(i_ready), 32'd0);
        checkOutput("rst_dp_ce", 32'(dp_ce), 32'd0);
        checkOutput("rst_o_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_o_data", 32'(o_data), 32'd0);
        checkOutput("rst_flush_done", 32'(flush_done), 32'd0);
        checkOutput("rst_occ", 32'(occ), 32'd0);
        nextCycle();
        nextCycle();
        rst = 1'b0;

        // Streaming with downstream always ready
        $display("[TB] streaming tags 1..10");
        peakOcc = 0;
        popBase = popCount;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 8'(k + 1), 1'b1, 1'b0, 1'b1);
            if (k == 0) checkOutput("t1_accept", 32'(i_ready), 32'd1);
            if (k == OUT_LAT - 1) checkOutput("t1_not_yet", 32'(o_valid), 32'd0);
            if (k == OUT_LAT) begin
                checkOutput("t1_first_valid", 32'(o_valid), 32'd1);
                checkOutput("t1_first_tag", 32'(o_data), 32'd1);
            end
            nextCycle();
        end
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) nextCycle();
        checkOutput("t1_drained", 32'(expQueue.size()), 32'd0);
        checkOutput("t1_count", 32'(popCount - popBase), 32'd10);
        checkOutput("t1_peak", 32'(peakOcc), 32'(OCC_PEAK1));

        // Backpressure: downstream stalls, intake must stop
        $display("[TB] backpressure");
        popBase = popCount;
        tag = 8'd11;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, tag, 1'b0, 1'b0, 1'b1);
            if (k == 11) begin
                checkOutput("t2_dp_ce_stall", 32'(dp_ce), 32'd0);
                checkOutput("t2_ready_stall", 32'(i_ready), 32'd0);
                checkOutput("t2_occ_full", 32'(occ), 32'(OCC_FULL));
                checkOutput("t2_valid_held", 32'(o_valid), 32'd1);
            end
            accepted = i_ready;
            nextCycle();
            if (accepted) begin
                acc++;
                tag++;
            end
        end
        checkOutput("t2_accepted", 32'(acc), 32'(OCC_FULL));
        applyStimulus(1'b0, tag, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 15; k++) nextCycle();
        checkOutput("t2_drained", 32'(expQueue.size()), 32'd0);
        checkOutput("t2_count", 32'(popCount - popBase), 32'(OCC_FULL));

        // Flush with an accept in the request cycle
        $display("[TB] flush");
        popBase = popCount;
        doneCount = 0;
        doneAt = -1;
        for (int k = 0; k < 15; k++) begin
            applyStimulus(k <= 4, 8'(21 + k), 1'b1, k == 3, 1'b1);
            if (k == 3) checkOutput("t3_accept_at_flush", 32'(i_ready), 32'd1);
            if (k == 4) checkOutput("t3_ready_after", 32'(i_ready), 32'd0);
            if (k == FLUSH_CYC + 1) checkOutput("t3_run_again", 32'(i_ready), 32'd1);
            if (flush_done) begin
                doneCount++;
                doneAt = k;
                checkOutput("t3_occ_at_done", 32'(occ), 32'd0);
            end
            nextCycle();
        end
        checkOutput("t3_done_pulses", 32'(doneCount), 32'd1);
        checkOutput("t3_done_cycle", 32'(doneAt), 32'(FLUSH_CYC));
        checkOutput("t3_count", 32'(popCount - popBase), 32'd4);
        checkOutput("t3_drained", 32'(expQueue.size()), 32'd0);

        // Clock enable toggling during streaming
        $display("[TB] ce toggling");
        popBase = popCount;
        tag = 8'd51;
        acc = 0;
        occHold = '0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, tag, 1'b1, 1'b0, (k % 2) == 0);
            if ((k % 2) == 1) begin
                checkOutput("t4_dp_ce_low", 32'(dp_ce), 32'd0);
                checkOutput("t4_ready_low", 32'(i_ready), 32'd0);
            end
            if (k == 7) occHold = occ;
            accepted = i_ready;
            nextCycle();
            if (k == 7) checkOutput("t4_occ_hold", 32'(occ), 32'(occHold));
            if (accepted) begin
                acc++;
                tag++;
            end
        end
        applyStimulus(1'b0, tag, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 15; k++) nextCycle();
        checkOutput("t4_accepted", 32'(acc), 32'd10);
        checkOutput("t4_count", 32'(popCount - popBase), 32'd10);
        checkOutput("t4_drained", 32'(expQueue.size()), 32'd0);

        // Reset in the middle of a drain
        $display("[TB] reset during drain");
        applyStimulus(1'b1, 8'd41, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 8'd42, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 8'd43, 1'b0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 8'd43, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_occ_drain", 32'(occ), 32'd2);
        checkOutput("t5_ready_drain", 32'(i_ready), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_occ", 32'(occ), 32'd0);
        checkOutput("t5_rst_valid", 32'(o_valid), 32'd0);
        checkOutput("t5_rst_done", 32'(flush_done), 32'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("t5_run_after", 32'(i_ready), 32'd1);

        // Flush on an empty pipeline still passes through DRAIN
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("t5_empty_drain_ready", 32'(i_ready), 32'd0);
        checkOutput("t5_empty_no_done", 32'(flush_done), 32'd0);
        nextCycle();
        checkOutput("t5_empty_done", 32'(flush_done), 32'd1);
        nextCycle();
        checkOutput("t5_done_once", 32'(flush_done), 32'd0);

        // Random downstream readiness over many tokens
        $display("[TB] random o_ready");
        popBase = popCount;
        peakOcc = 0;
        tag = 8'd0;
        acc = 0;
        cycles = 0;
        while (acc < 1000 && cycles < 20000) begin
            applyStimulus(1'b1, tag, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            accepted = i_ready;
            nextCycle();
            cycles++;
            if (accepted) begin
                acc++;
                tag++;
            end
        end
        checkOutput("t6_accepted", 32'(acc), 32'd1000);
        applyStimulus(1'b0, tag, 1'b1, 1'b0, 1'b1);
        cycles = 0;
        while (expQueue.size() != 0 && cycles < 200) begin
            nextCycle();
            cycles++;
        end
        checkOutput("t6_drained", 32'(expQueue.size()), 32'd0);
        checkOutput("t6_count", 32'(popCount - popBase), 32'd1000);
        checkOutput("t6_peak_bound", 32'(peakOcc <= OCC_MAX), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
